// File: rtl/wisc_mem_pkg.sv
// Shared types and widths for the data-memory responder slice.
package wisc_mem_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port data RAM: synchronous write, registered read (rdata_q).
import wisc_mem_pkg::*;

module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Contents deliberately unreset so committed stores survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// LW/SW responder: accepts one request, stalls LATENCY cycles, pulses memDone once.
import wisc_mem_pkg::*;

module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enableMem,
    input  logic              readWriteMem,
    input  logic [15:0]       memAddr,
    input  logic [WORD_W-1:0] memWData,
    output logic [WORD_W-1:0] memRData,
    output logic              memDone,
    output logic              memStall
);

    dmem_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    logic             unused_addr_bits;

    // Array access happens on the acceptance edge, so later input changes cannot affect it.
    assign accept           = (state == IDLE) && enableMem && !rst;
    assign unused_addr_bits = ^{memAddr[15:ADDR_W+1], memAddr[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (enableMem) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                // A dropped enableMem is a pipeline flush: abandon without memDone.
                if (!enableMem || cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign memDone  = (state == BUSY) && (cnt == '0) && enableMem;
    assign memStall = enableMem && !memDone;

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (accept && readWriteMem),
        .re   (accept && !readWriteMem),
        .addr (memAddr[ADDR_W:1]),
        .wdata(memWData),
        .rdata(memRData)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: LATENCY=4 instance for directed cases, LATENCY=1 instance for random ops.
module tb_dmem_responder;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, rw_a, en_b, rw_b;
    logic [15:0] addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;
    logic        done_a, stall_a, done_b, stall_b;

    int   checks   = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic [15:0] mb [1024];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(4)) dut_a (
        .clk(clk), .rst(rst), .enableMem(en_a), .readWriteMem(rw_a),
        .memAddr(addr_a), .memWData(wd_a), .memRData(rd_a),
        .memDone(done_a), .memStall(stall_a)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .enableMem(en_b), .readWriteMem(rw_b),
        .memAddr(addr_b), .memWData(wd_b), .memRData(rd_b),
        .memDone(done_b), .memStall(stall_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT signals completion.
    always @(negedge clk) begin
        if (done_a) begin
            if (qa.size() == 0) check("a_spurious_done", 1, 0);
            else begin
                ea = qa.pop_front();
                if (ea.is_read) check("a_rdata", rd_a, ea.data);
            end
        end
        if (done_b) begin
            if (qb.size() == 0) check("b_spurious_done", 1, 0);
            else begin
                eb = qb.pop_front();
                if (eb.is_read) check("b_rdata", rd_b, eb.data);
            end
        end
    end

    // Holds the request until memDone, leaves enableMem high for back-to-back use.
    task automatic op_a(input logic rw, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp, output int cyc);
        int stalls = 0;
        bit got = 0;
        qa.push_back('{is_read: !rw, data: exp});
        en_a = 1'b1; rw_a = rw; addr_a = a; wd_a = d;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (stall_a) stalls++;
            if (done_a) got = 1;
            @(posedge clk); #1;
        end
        check("a_done_seen", 32'(got), 1);
        check("a_cycles", 32'(cyc), 5);
        check("a_stall_cycles", 32'(stalls), 4);
    endtask

    task automatic op_b(input logic rw, input logic [15:0] a, input logic [15:0] d);
        int stalls = 0;
        int cyc = 0;
        bit got = 0;
        qb.push_back('{is_read: !rw, data: rw ? 16'h0 : mb[a[10:1]]});
        if (rw) mb[a[10:1]] = d;
        en_b = 1'b1; rw_b = rw; addr_b = a; wd_b = d;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (stall_b) stalls++;
            if (done_b) got = 1;
            @(posedge clk); #1;
        end
        check("b_cycles", 32'(cyc), 2);
        check("b_stall_cycles", 32'(stalls), 1);
    endtask

    task automatic idle_a(input int n);
        en_a = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, total;
        logic [15:0] a, d;
        rst = 1'b1;
        en_a = 0; rw_a = 0; addr_a = '0; wd_a = '0;
        en_b = 0; rw_b = 0; addr_b = '0; wd_b = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_rdata", rd_a, 16'h0);
        check("reset_done", 32'(done_a), 0);
        check("reset_stall_idle", 32'(stall_a), 0);
        en_a = 1'b1;
        @(negedge clk);
        check("reset_stall_follows_en", 32'(stall_a), 1);
        check("reset_no_done", 32'(done_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_a(1);

        // Basic SW then LW
        op_a(1, 16'h0010, 16'hBEEF, 16'h0, c);
        op_a(0, 16'h0010, 16'h0, 16'hBEEF, c);
        idle_a(1);

        // Bit 0 ignored, upper bits alias
        op_a(1, 16'h0010, 16'h1234, 16'h0, c);
        op_a(0, 16'h0011, 16'h0, 16'h1234, c);
        op_a(0, 16'h0810, 16'h0, 16'h1234, c);
        idle_a(1);

        // Back-to-back SW/LW/SW with enableMem held continuously
        total = 0;
        op_a(1, 16'h0040, 16'h1111, 16'h0, c); total += c;
        op_a(0, 16'h0040, 16'h0, 16'h1111, c); total += c;
        op_a(1, 16'h0042, 16'h2222, 16'h0, c); total += c;
        check("b2b_total_cycles", 32'(total), 15);
        op_a(0, 16'h0042, 16'h0, 16'h2222, c);
        idle_a(1);

        // Flush at cnt=2: write already committed, no memDone, immediate re-accept
        op_a(1, 16'h0050, 16'h6666, 16'h0, c);
        idle_a(1);
        en_a = 1'b1; rw_a = 1'b1; addr_a = 16'h0050; wd_a = 16'h7777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        en_a = 1'b0;
        @(negedge clk);
        check("flush_no_done", 32'(done_a), 0);
        check("flush_no_stall", 32'(stall_a), 0);
        @(posedge clk); #1;
        op_a(0, 16'h0050, 16'h0, 16'h7777, c);
        idle_a(1);

        // Reset mid-BUSY of a SW
        op_a(1, 16'h0020, 16'hCAFE, 16'h0, c);
        idle_a(1);
        en_a = 1'b1; rw_a = 1'b1; addr_a = 16'h0030; wd_a = 16'h5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_no_done", 32'(done_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        en_a = 1'b0;
        @(negedge clk);
        check("post_rst_rdata", rd_a, 16'h0);
        check("post_rst_done", 32'(done_a), 0);
        @(posedge clk); #1;
        op_a(0, 16'h0030, 16'h0, 16'h5A5A, c);
        op_a(0, 16'h0020, 16'h0, 16'hCAFE, c);
        idle_a(1);

        // LATENCY=1: initialise 32 words, then 1000 random ops with aliased addresses
        for (int i = 0; i < 32; i++) begin
            a = 16'($urandom);
            a[10:1] = 10'(i);
            op_b(1, a, 16'($urandom));
        end
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            a[10:1] = 10'($urandom_range(0, 31));
            d = 16'($urandom);
            op_b(1'($urandom_range(0, 1)), a, d);
        end
        en_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("a_queue_drained", 32'(qa.size()), 0);
        check("b_queue_drained", 32'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
